// File: rtl/brush_motor_hbridge_pwm.sv
// rtl/brush_motor_hbridge_pwm.sv - H-bridge gate driver with PWM speed control and dead-time insertion.
// Optional fault input enabled by defining BRUSH_HBRIDGE_FAULT_EN.
module brush_motor_hbridge_pwm #(
   parameter int PWM_W    = 16,
   parameter int DT_W     = 8,
   parameter int DT_RESET = 16
) (
   input  logic        csi_MCLK_clk,
   input  logic        rsi_MRST_reset,
   input  logic [31:0] avs_ctrl_writedata,
   output logic [31:0] avs_ctrl_readdata,
   input  logic [1:0]  avs_ctrl_address,
   input  logic        avs_ctrl_write,
   input  logic        avs_ctrl_read,
   input  logic        hx_in,
   input  logic        hy_in,
`ifdef BRUSH_HBRIDGE_FAULT_EN
   input  logic        fault_n,
`endif
   output logic        gate_ah,
   output logic        gate_al,
   output logic        gate_bh,
   output logic        gate_bl
);

   typedef enum logic [1:0] {S_OFF = 2'd0, S_DEAD = 2'd1, S_RUN = 2'd2} state_t;

   localparam logic [1:0] M_COAST = 2'b00;
   localparam logic [1:0] M_REV   = 2'b01;
   localparam logic [1:0] M_FWD   = 2'b10;
   localparam logic [1:0] M_BRAKE = 2'b11;

   logic [PWM_W-1:0] period_reg, duty_reg;
   logic [DT_W-1:0]  dt_reg, dt_cnt, dt_load;
   logic [PWM_W-1:0] cnt, p_act, d_act;
   logic             pwm_on;
   state_t           state;
   logic [1:0]       mode_lat, mode_in;
   logic [3:0]       gates;
   logic             fault_latch, fault_hold;
   logic             unused_wdata;

   assign mode_in      = {hx_in, hy_in};
   assign dt_load      = (dt_reg == '0) ? DT_W'(1) : dt_reg;
   assign pwm_on       = (p_act != '0) && (cnt < d_act);
   assign unused_wdata = &{1'b0, avs_ctrl_writedata[31:PWM_W]};
   assign {gate_ah, gate_al, gate_bh, gate_bl} = gates;

   function automatic logic [3:0] gate_map(input logic [1:0] m, input logic on);
      case (m)
         M_FWD:   gate_map = {on, 1'b0, 1'b0, 1'b1};
         M_REV:   gate_map = {1'b0, 1'b1, on, 1'b0};
         M_BRAKE: gate_map = 4'b0101;
         default: gate_map = 4'b0000;
      endcase
   endfunction

`ifdef BRUSH_HBRIDGE_FAULT_EN
   logic fault_s1, fault_s2;

   // Synchronizer resets to "no fault"; a live low still latches two edges later.
   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         fault_s1    <= 1'b1;
         fault_s2    <= 1'b1;
         fault_latch <= 1'b0;
      end else begin
         fault_s1 <= fault_n;
         fault_s2 <= fault_s1;
         if (!fault_s2)
            fault_latch <= 1'b1;
         else if (avs_ctrl_write && avs_ctrl_address == 2'd3 && avs_ctrl_writedata[0])
            fault_latch <= 1'b0;
      end
   end

   assign fault_hold = fault_latch | ~fault_s2;
`else
   assign fault_latch = 1'b0;
   assign fault_hold  = 1'b0;
`endif

   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         period_reg <= '0;
         duty_reg   <= '0;
         dt_reg     <= DT_W'(DT_RESET);
      end else if (avs_ctrl_write) begin
         case (avs_ctrl_address)
            2'd0:    period_reg <= avs_ctrl_writedata[PWM_W-1:0];
            2'd1:    duty_reg   <= avs_ctrl_writedata[PWM_W-1:0];
            2'd2:    dt_reg     <= avs_ctrl_writedata[DT_W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         avs_ctrl_readdata <= '0;
      end else if (avs_ctrl_read) begin
         case (avs_ctrl_address)
            2'd0:    avs_ctrl_readdata <= 32'(period_reg);
            2'd1:    avs_ctrl_readdata <= 32'(duty_reg);
            2'd2:    avs_ctrl_readdata <= 32'(dt_reg);
            default: avs_ctrl_readdata <= {27'd0, fault_latch, mode_lat, state};
         endcase
      end
   end

   // Active period/duty only reload at the wrap so a duty change never produces a runt pulse.
   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         cnt   <= '0;
         p_act <= '0;
         d_act <= '0;
      end else if (p_act == '0 || cnt == p_act - 1'b1) begin
         cnt   <= '0;
         p_act <= period_reg;
         d_act <= duty_reg;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Gates are loaded from the state being entered, so RUN outputs appear on the edge leaving DEAD.
   always_ff @(posedge csi_MCLK_clk) begin
      if (rsi_MRST_reset) begin
         state    <= S_OFF;
         mode_lat <= M_COAST;
         dt_cnt   <= '0;
         gates    <= 4'b0000;
      end else if (fault_hold) begin
         state    <= S_OFF;
         mode_lat <= M_COAST;
         gates    <= 4'b0000;
      end else begin
         case (state)
            S_OFF: begin
               gates <= 4'b0000;
               if (mode_in != M_COAST) begin
                  state    <= S_DEAD;
                  mode_lat <= mode_in;
                  dt_cnt   <= dt_load;
               end
            end
            S_DEAD: begin
               if (mode_in != mode_lat) begin
                  mode_lat <= mode_in;
                  dt_cnt   <= dt_load;
                  gates    <= 4'b0000;
               end else if (dt_cnt <= DT_W'(1)) begin
                  state <= (mode_lat == M_COAST) ? S_OFF : S_RUN;
                  gates <= gate_map(mode_lat, pwm_on);
               end else begin
                  dt_cnt <= dt_cnt - 1'b1;
                  gates  <= 4'b0000;
               end
            end
            S_RUN: begin
               if (mode_in != mode_lat) begin
                  state    <= S_DEAD;
                  mode_lat <= mode_in;
                  dt_cnt   <= dt_load;
                  gates    <= 4'b0000;
               end else begin
                  gates <= gate_map(mode_lat, pwm_on);
               end
            end
            default: begin
               state <= S_OFF;
               gates <= 4'b0000;
            end
         endcase
      end
   end

endmodule
